// File: rtl/pipe_pkg.sv
// pipe_pkg: shared pipeline widths, control-bundle layout and immediate extension.
package pipe_pkg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 8;
  localparam int CTRL_ALUOP_LSB = 0;
  localparam int CTRL_ALUOP_W = 4;
  localparam int CTRL_MEMWR = 4;
  localparam int CTRL_MEMTOREG = 5;
  localparam int CTRL_BRANCH = 6;
  localparam logic [CW-1:0] CTRL_BUBBLE = '0;
  function automatic logic [DW-1:0] ext_imm(input logic [15:0] imm, input logic zext);
    return {{(DW-16){~zext & imm[15]}}, imm};
  endfunction
endpackage

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: load-use hazard detection and the upstream stall request it implies.
module id_hazard_unit
  import pipe_pkg::*;
#(
  parameter int RW_P = RW
) (
  input  logic            id_valid,
  input  logic [RW_P-1:0] id_rs,
  input  logic [RW_P-1:0] id_rt,
  input  logic            id_uses_rt,
  input  logic            ex_valid,
  input  logic            ex_memrd,
  input  logic            ex_regwr,
  input  logic [RW_P-1:0] ex_rd,
  input  logic            ex_flush,
  output logic            hazard,
  output logic            stall_out
);
  assign hazard = id_valid && ex_valid && ex_memrd && ex_regwr &&
                  (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
  assign stall_out = hazard && !ex_flush;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with WB write-through bypass,
// load-use bubble insertion, EX flush and downstream hold.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW_P = DW,
  parameter int RW_P = RW,
  parameter int CW_P = CW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RW_P-1:0] id_rs,
  input  logic [RW_P-1:0] id_rt,
  input  logic [RW_P-1:0] id_rd,
  input  logic            id_uses_rt,
  input  logic [15:0]     id_imm16,
  input  logic            id_zext,
  input  logic [CW_P-1:0] id_ctrl,
  input  logic            id_regwr,
  input  logic            id_memrd,
  input  logic [DW_P-1:0] busa_in,
  input  logic [DW_P-1:0] busb_in,
  input  logic            wb_regwr,
  input  logic [RW_P-1:0] wb_rw,
  input  logic [DW_P-1:0] wb_data,
  input  logic            ex_flush,
  input  logic            ex_hold,
  output logic            stall_out,
  output logic            ex_valid,
  output logic            ex_regwr,
  output logic            ex_memrd,
  output logic [RW_P-1:0] ex_rs,
  output logic [RW_P-1:0] ex_rt,
  output logic [RW_P-1:0] ex_rd,
  output logic [DW_P-1:0] ex_a,
  output logic [DW_P-1:0] ex_b,
  output logic [DW_P-1:0] ex_imm,
  output logic [CW_P-1:0] ex_ctrl
);
  logic            valid_q, valid_d, regwr_q, regwr_d, memrd_q, memrd_d;
  logic [RW_P-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DW_P-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [CW_P-1:0] ctrl_q, ctrl_d;
  logic [DW_P-1:0] op_a, op_b;
  logic            hazard;

  id_hazard_unit #(.RW_P(RW_P)) u_hazard (
    .id_valid  (id_valid),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_uses_rt(id_uses_rt),
    .ex_valid  (valid_q),
    .ex_memrd  (memrd_q),
    .ex_regwr  (regwr_q),
    .ex_rd     (rd_q),
    .ex_flush  (ex_flush),
    .hazard    (hazard),
    .stall_out (stall_out)
  );

  // Register file writes land at the edge, so same-cycle reads are stale.
  assign op_a = (wb_regwr && wb_rw == id_rs) ? wb_data : busa_in;
  assign op_b = (wb_regwr && wb_rw == id_rt) ? wb_data : busb_in;

  always_comb begin
    valid_d = valid_q;
    regwr_d = regwr_q;
    memrd_d = memrd_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    ctrl_d  = ctrl_q;
    if (ex_flush || (!ex_hold && hazard)) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      memrd_d = 1'b0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      a_d     = '0;
      b_d     = '0;
      imm_d   = '0;
      ctrl_d  = CW_P'(CTRL_BUBBLE);
    end else if (ex_hold) begin
      a_d = (valid_q && wb_regwr && wb_rw == rs_q) ? wb_data : a_q;
      b_d = (valid_q && wb_regwr && wb_rw == rt_q) ? wb_data : b_q;
    end else begin
      valid_d = id_valid;
      regwr_d = id_valid && id_regwr;
      memrd_d = id_valid && id_memrd;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      a_d     = op_a;
      b_d     = op_b;
      imm_d   = DW_P'(ext_imm(id_imm16, id_zext));
      ctrl_d  = id_valid ? id_ctrl : CW_P'(CTRL_BUBBLE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      memrd_q <= 1'b0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      memrd_q <= memrd_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_regwr = regwr_q;
  assign ex_memrd = memrd_q;
  assign ex_rs    = rs_q;
  assign ex_rt    = rt_q;
  assign ex_rd    = rd_q;
  assign ex_a     = a_q;
  assign ex_b     = b_q;
  assign ex_imm   = imm_q;
  assign ex_ctrl  = ctrl_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed scenario tests for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_uses_rt, id_zext, id_regwr, id_memrd;
  logic [4:0]  id_rs, id_rt, id_rd, wb_rw;
  logic [15:0] id_imm16;
  logic [7:0]  id_ctrl;
  logic [31:0] busa_in, busb_in, wb_data;
  logic        wb_regwr, ex_flush, ex_hold;
  logic        stall_out, ex_valid, ex_regwr, ex_memrd;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_a, ex_b, ex_imm;
  logic [7:0]  ex_ctrl;
  int tests = 0;
  int fails = 0;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_imm16(id_imm16), .id_zext(id_zext),
    .id_ctrl(id_ctrl), .id_regwr(id_regwr), .id_memrd(id_memrd), .busa_in(busa_in),
    .busb_in(busb_in), .wb_regwr(wb_regwr), .wb_rw(wb_rw), .wb_data(wb_data),
    .ex_flush(ex_flush), .ex_hold(ex_hold), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_uses_rt = 0; id_imm16 = 0;
    id_zext = 0; id_ctrl = 0; id_regwr = 0; id_memrd = 0; busa_in = 0; busb_in = 0;
    wb_regwr = 0; wb_rw = 0; wb_data = 0; ex_flush = 0; ex_hold = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_r7();
    idle();
    id_valid = 1; id_memrd = 1; id_regwr = 1; id_rd = 7; id_rs = 1;
    step();
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    #12;
    tests++; if (ex_valid !== 1'b0 || ex_a !== 0 || ex_ctrl !== 0) begin fails++; $display("FAIL reset_init valid=%b a=%h ctrl=%h want 0", ex_valid, ex_a, ex_ctrl); end
    rst = 1;
    id_valid = 1; id_regwr = 1; id_ctrl = 8'h5A; busa_in = 32'h1234; id_rd = 4;
    step();
    tests++; if (ex_valid !== 1'b1 || ex_ctrl !== 8'h5A) begin fails++; $display("FAIL reset_pre valid=%b ctrl=%h want 1/5a", ex_valid, ex_ctrl); end
    #2 rst = 0;
    #1;
    tests++; if ({ex_valid, ex_regwr, ex_memrd, ex_rs, ex_rt, ex_rd, ex_a, ex_b, ex_imm, ex_ctrl} !== '0) begin fails++; $display("FAIL reset_async valid=%b regwr=%b a=%h ctrl=%h want all 0", ex_valid, ex_regwr, ex_a, ex_ctrl); end
    @(negedge clk);
    rst = 1;
    idle();
    id_valid = 1; id_rs = 3; busa_in = 32'h11;
    step();
    tests++; if (ex_a !== 32'h11 || ex_valid !== 1'b1) begin fails++; $display("FAIL reset_release a=%h valid=%b want 11/1", ex_a, ex_valid); end
  endtask

  task automatic test_bypass();
    idle();
    id_valid = 1; id_rs = 5; id_rt = 5;
    wb_regwr = 1; wb_rw = 5; wb_data = 32'hDEADBEEF;
    step();
    tests++; if (ex_a !== 32'hDEADBEEF || ex_b !== 32'hDEADBEEF) begin fails++; $display("FAIL bypass_on a=%h b=%h want deadbeef", ex_a, ex_b); end
    wb_regwr = 0;
    step();
    tests++; if (ex_a !== 0 || ex_b !== 0) begin fails++; $display("FAIL bypass_off a=%h b=%h want 0", ex_a, ex_b); end
    wb_regwr = 1; id_rt = 6; busb_in = 32'h22; busa_in = 32'h33;
    step();
    tests++; if (ex_a !== 32'hDEADBEEF || ex_b !== 32'h22) begin fails++; $display("FAIL bypass_a_only a=%h b=%h want deadbeef/22", ex_a, ex_b); end
  endtask

  task automatic test_invalid_capture();
    idle();
    id_regwr = 1; id_memrd = 1; id_ctrl = 8'hFF;
    step();
    tests++; if (ex_valid !== 0 || ex_regwr !== 0 || ex_memrd !== 0 || ex_ctrl !== 0) begin fails++; $display("FAIL invalid_capture v=%b rw=%b mr=%b ctrl=%h want 0", ex_valid, ex_regwr, ex_memrd, ex_ctrl); end
  endtask

  task automatic test_load_use();
    load_r7();
    tests++; if (ex_memrd !== 1 || ex_regwr !== 1 || ex_rd !== 7) begin fails++; $display("FAIL lu_load mr=%b rw=%b rd=%0d want 1/1/7", ex_memrd, ex_regwr, ex_rd); end
    idle();
    id_valid = 1; id_regwr = 1; id_rd = 8; id_rs = 1; id_rt = 7; id_uses_rt = 1; id_ctrl = 8'h11;
    #1;
    tests++; if (stall_out !== 1) begin fails++; $display("FAIL lu_stall stall=%b want 1", stall_out); end
    step();
    tests++; if (ex_valid !== 0 || stall_out !== 0) begin fails++; $display("FAIL lu_bubble valid=%b stall=%b want 0/0", ex_valid, stall_out); end
    step();
    tests++; if (ex_valid !== 1 || ex_rd !== 8 || ex_ctrl !== 8'h11) begin fails++; $display("FAIL lu_enter valid=%b rd=%0d ctrl=%h want 1/8/11", ex_valid, ex_rd, ex_ctrl); end
    load_r7();
    idle();
    id_valid = 1; id_rs = 1; id_rt = 7; id_uses_rt = 0;
    #1;
    tests++; if (stall_out !== 0) begin fails++; $display("FAIL lu_no_rt stall=%b want 0", stall_out); end
    id_rs = 7;
    #1;
    tests++; if (stall_out !== 1) begin fails++; $display("FAIL lu_rs stall=%b want 1", stall_out); end
  endtask

  task automatic test_back_to_back();
    load_r7();
    idle();
    id_valid = 1; id_memrd = 1; id_regwr = 1; id_rd = 7; id_rs = 7;
    #1;
    tests++; if (stall_out !== 1) begin fails++; $display("FAIL b2b_stall1 stall=%b want 1", stall_out); end
    step();
    tests++; if (ex_valid !== 0 || stall_out !== 0) begin fails++; $display("FAIL b2b_bubble1 valid=%b stall=%b want 0/0", ex_valid, stall_out); end
    step();
    tests++; if (ex_valid !== 1 || ex_memrd !== 1) begin fails++; $display("FAIL b2b_load2 valid=%b mr=%b want 1/1", ex_valid, ex_memrd); end
    idle();
    id_valid = 1; id_rs = 7; id_rd = 9; id_regwr = 1;
    #1;
    tests++; if (stall_out !== 1) begin fails++; $display("FAIL b2b_stall2 stall=%b want 1", stall_out); end
    step();
    tests++; if (ex_valid !== 0) begin fails++; $display("FAIL b2b_bubble2 valid=%b want 0", ex_valid); end
    step();
    tests++; if (ex_valid !== 1 || ex_rd !== 9 || ex_memrd !== 0) begin fails++; $display("FAIL b2b_enter valid=%b rd=%0d mr=%b want 1/9/0", ex_valid, ex_rd, ex_memrd); end
  endtask

  task automatic test_flush();
    load_r7();
    idle();
    id_valid = 1; id_rs = 7; id_ctrl = 8'hA5; id_regwr = 1; ex_flush = 1;
    #1;
    tests++; if (stall_out !== 0) begin fails++; $display("FAIL flush_stall stall=%b want 0", stall_out); end
    step();
    tests++; if (ex_valid !== 0 || ex_ctrl !== 0 || ex_regwr !== 0) begin fails++; $display("FAIL flush_bubble valid=%b ctrl=%h rw=%b want 0", ex_valid, ex_ctrl, ex_regwr); end
  endtask

  task automatic test_hold();
    idle();
    id_valid = 1; id_rs = 9; busa_in = 32'h1; id_rt = 4; busb_in = 32'h44;
    id_rd = 2; id_ctrl = 8'h3C; id_regwr = 1; id_imm16 = 16'h0123;
    step();
    tests++; if (ex_a !== 32'h1 || ex_rs !== 9) begin fails++; $display("FAIL hold_setup a=%h rs=%0d want 1/9", ex_a, ex_rs); end
    idle();
    id_valid = 1; id_rs = 3; id_rd = 6; id_ctrl = 8'hFF; busa_in = 32'h77;
    ex_hold = 1; wb_regwr = 1; wb_rw = 9; wb_data = 32'h55;
    step();
    tests++; if (ex_a !== 32'h55 || ex_b !== 32'h44 || ex_rd !== 2 || ex_ctrl !== 8'h3C || ex_valid !== 1 || ex_imm !== 32'h123 || ex_regwr !== 1) begin fails++; $display("FAIL hold_refresh a=%h b=%h rd=%0d ctrl=%h v=%b imm=%h want 55/44/2/3c/1/123", ex_a, ex_b, ex_rd, ex_ctrl, ex_valid, ex_imm); end
    wb_rw = 4; wb_data = 32'h66;
    step();
    tests++; if (ex_a !== 32'h55 || ex_b !== 32'h66) begin fails++; $display("FAIL hold_refresh_b a=%h b=%h want 55/66", ex_a, ex_b); end
    ex_flush = 1;
    step();
    tests++; if (ex_valid !== 0 || ex_ctrl !== 0) begin fails++; $display("FAIL hold_flush valid=%b ctrl=%h want 0/0", ex_valid, ex_ctrl); end
    load_r7();
    idle();
    id_valid = 1; id_rs = 7; ex_hold = 1;
    #1;
    tests++; if (stall_out !== 1) begin fails++; $display("FAIL hold_hazard_stall stall=%b want 1", stall_out); end
    step();
    tests++; if (ex_valid !== 1 || ex_memrd !== 1 || ex_rd !== 7) begin fails++; $display("FAIL hold_hazard_keep v=%b mr=%b rd=%0d want 1/1/7", ex_valid, ex_memrd, ex_rd); end
  endtask

  task automatic test_imm();
    idle();
    id_valid = 1; id_imm16 = 16'h8001; id_zext = 0;
    step();
    tests++; if (ex_imm !== 32'hFFFF8001) begin fails++; $display("FAIL imm_sext got %h want ffff8001", ex_imm); end
    id_zext = 1;
    step();
    tests++; if (ex_imm !== 32'h00008001) begin fails++; $display("FAIL imm_zext got %h want 00008001", ex_imm); end
    id_imm16 = 16'h7FFF; id_zext = 0;
    step();
    tests++; if (ex_imm !== 32'h00007FFF) begin fails++; $display("FAIL imm_pos got %h want 00007fff", ex_imm); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_invalid_capture();
    test_load_use();
    test_back_to_back();
    test_flush();
    test_hold();
    test_imm();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the register file read ports (BusA/BusB).
- Each cycle it latches the decoded instruction, operand values and control bundle for EX.
- Applies WB->ID write-through bypass: the register file write lands at the clock edge, so a same-cycle read would return stale data.
- Detects load-use hazards, requests an upstream stall and inserts bubbles. Honours EX flush and downstream hold.

Parameters:
- DW, 32, datapath width
- RW, 5, register index width
- CW, 8, opaque EX/MEM/WB control bundle width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- id_valid  in  1  decode holds a real instruction
- id_rs, id_rt  in  RW  source indices; also drive register file Rs/Rt
- id_rd  in  RW  destination index, already muxed by decode
- id_uses_rt  in  1  instruction reads rt
- id_imm16  in  16  immediate field
- id_zext  in  1  1 = zero-extend immediate, 0 = sign-extend
- id_ctrl  in  CW  control bundle
- id_regwr, id_memrd  in  1  writes a register / is a load
- busa_in, busb_in  in  DW  register file read data
- wb_regwr, wb_rw, wb_data  in  1/RW/DW  WB write port; same nets as the register file RegWr/Rw/Data_in
- ex_flush  in  1  kill the instruction entering EX (branch/jump resolved)
- ex_hold  in  1  downstream stall; freeze EX contents
- stall_out  out  1  load-use stall request to IF/ID (combinational)
- ex_valid, ex_regwr, ex_memrd  out  1  latched qualifiers
- ex_rs, ex_rt, ex_rd  out  RW  latched indices
- ex_a, ex_b  out  DW  latched operands
- ex_imm  out  DW  extended immediate
- ex_ctrl  out  CW  latched control bundle

Behaviour:
- Reset (rst=0, async): every registered output is 0, so ex_valid=0 and the stage holds a bubble. A mid-operation reset drops the in-flight instruction with no partial update.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- Bypass (combinational, before capture):
  - op_a = wb_data if wb_regwr && wb_rw==id_rs, else busa_in. op_b likewise with id_rt.
  - r0 is an ordinary writable register in this core; no zero special-case.
- Immediate: id_zext=1 -> {16'b0, imm}; id_zext=0 -> replicate imm MSB into the upper 16 bits.
- hazard (combinational): id_valid && ex_valid && ex_memrd && ex_regwr && (ex_rd==id_rs || (id_uses_rt && ex_rd==id_rt)).
- stall_out = hazard && !ex_flush.
- Clock-edge update priority, first match wins:
  1. ex_flush: load bubble (ex_valid, ex_regwr, ex_memrd, ex_ctrl = 0; data fields don't-care, drive 0).
  2. ex_hold: keep all fields, except operand refresh: if ex_valid && wb_regwr && wb_rw==ex_rs then ex_a<=wb_data. Same for ex_rt/ex_b. This keeps held operands coherent with the register file.
  3. hazard: load bubble. The ID instruction stays upstream because stall_out is high.
  4. Otherwise: capture ID inputs with bypassed operands. ex_valid<=id_valid. If id_valid=0, force ex_regwr, ex_memrd and ex_ctrl to 0.
- hold && hazard: hold wins for EX; stall_out is still asserted, so upstream must freeze under either signal.
- flush && hold: flush wins; EX becomes a bubble.
- Back-to-back loads to the same register: exactly one bubble per dependent consumer.
- No internal state besides the pipeline register; no FSM beyond valid/bubble.

Decomposition:
- Shared package (pipe_pkg):
  - DW, RW, CW constants
  - ctrl field bit positions (ALU op, MemWr, MemToReg, Branch)
  - CTRL_BUBBLE constant (all zero)
  - immediate-extend function
- Sub-module id_hazard_unit: pure combinational hazard/stall_out logic, reused by the fetch controller for its stall view.

Test Plan:
- Reset: rst low mid-stream with ex_valid=1 -> all outputs 0 immediately, no clock required. Release, then load id_rs=3 (busa_in=0x11) -> next edge ex_a=0x11, ex_valid=1.
- WB bypass: wb_regwr=1, wb_rw=5, wb_data=0xDEADBEEF, id_rs=5, id_rt=5, bus inputs 0x0 -> ex_a=ex_b=0xDEADBEEF. Repeat with wb_regwr=0 -> 0x0.
- Load-use: EX holds a load (ex_memrd=1, ex_regwr=1, ex_rd=7); ID has id_rt=7, id_uses_rt=1 -> stall_out=1, one bubble (ex_valid=0). Next cycle stall_out=0 and the instruction enters. With id_uses_rt=0 -> no stall.
- Flush priority: ex_flush=1 with hazard present and id_valid=1 -> stall_out=0, next ex_valid=0, ex_ctrl=0.
- Hold refresh: ex_hold=1, ex_rs=9, ex_a=0x1; WB writes r9=0x55 -> ex_a=0x55, all other fields unchanged. ex_hold=1 and ex_flush=1 together -> bubble.
- Immediate: id_imm16=0x8001, id_zext=0 -> ex_imm=0xFFFF8001; id_zext=1 -> 0x00008001.
